// File: rtl/apply_next_frontier_ctrl.sv
// Next-frontier controller: per-lane FIFOs buffer updated vertex IDs; a global FSM
// drains them at iteration end, then advances or converges. APPLY_ITER_ID_CHECK_EN adds the iteration-ID check.
`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef CORE_NUM
`define CORE_NUM 32
`endif
`ifndef ITERATION_WIDTH
`define ITERATION_WIDTH 8
`endif

module apply_next_frontier_ctrl #(
  parameter int V_ID_WIDTH      = `V_ID_WIDTH,
  parameter int CORE_NUM        = `CORE_NUM,
  parameter int ITERATION_WIDTH = `ITERATION_WIDTH,
  parameter int FIFO_DEPTH      = 16,
  parameter logic [ITERATION_WIDTH-1:0] MAX_ITERATION = {ITERATION_WIDTH{1'b1}}
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CORE_NUM*V_ID_WIDTH-1:0]      front_active_v_id,
  input  logic [CORE_NUM-1:0]                 front_active_v_updated,
  input  logic [CORE_NUM-1:0]                 front_active_v_valid,
  input  logic [CORE_NUM-1:0]                 front_iteration_end,
  input  logic [CORE_NUM-1:0]                 front_iteration_end_valid,
  input  logic [CORE_NUM*ITERATION_WIDTH-1:0] front_iteration_id,
  input  logic [CORE_NUM-1:0]                 next_v_ready,
  output logic [CORE_NUM*V_ID_WIDTH-1:0]      next_v_id,
  output logic [CORE_NUM-1:0]                 next_v_valid,
  output logic [CORE_NUM-1:0]                 stall_front,
  output logic                                iteration_start,
  output logic [ITERATION_WIDTH-1:0]          iteration_id,
  output logic                                algorithm_done,
  output logic [CORE_NUM-1:0]                 overflow_err,
  output logic                                iter_mismatch,
  output logic [1:0]                          dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DRAIN   = 2'd1,
    S_ADVANCE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [V_ID_WIDTH-1:0]      r_mem [CORE_NUM][FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr [CORE_NUM];
  logic [AW-1:0]              r_rd_ptr [CORE_NUM];
  logic [CW-1:0]              r_count [CORE_NUM];
  logic [CORE_NUM-1:0]        r_stall;
  logic [CORE_NUM-1:0]        r_overflow;
  logic [CORE_NUM-1:0]        r_seen;
  logic [ITERATION_WIDTH-1:0] r_iteration_id;

  logic [CORE_NUM-1:0] w_push_req, w_push, w_pop, w_full, w_nonempty;
  logic                w_accept_state;
  logic                w_end_all;
  logic                w_iter_start;
  logic                w_done;

  assign w_accept_state = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_end_all      = &(front_iteration_end & front_iteration_end_valid);

  // A full lane still accepts a push when it pops in the same cycle.
  always_comb begin
    w_push_req = '0;
    w_push     = '0;
    w_pop      = '0;
    w_full     = '0;
    w_nonempty = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      w_nonempty[i] = (r_count[i] != '0);
      w_full[i]     = (r_count[i] == FULL_CNT);
      w_pop[i]      = w_nonempty[i] & next_v_ready[i];
      w_push_req[i] = front_active_v_valid[i] & front_active_v_updated[i] & w_accept_state;
      w_push[i]     = w_push_req[i] & (~w_full[i] | w_pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CORE_NUM; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr_ptr[i]] <= front_active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CORE_NUM; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_stall    <= '0;
      r_overflow <= '0;
      r_seen     <= '0;
    end else begin
      for (int i = 0; i < CORE_NUM; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
        r_count[i] <= r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
        // Registered from the current count to give upstream its two-cycle margin.
        r_stall[i] <= (r_count[i] >= STALL_CNT);
        if (w_push_req[i] && w_full[i] && !w_pop[i]) r_overflow[i] <= 1'b1;
        if (w_iter_start)   r_seen[i] <= 1'b0;
        else if (w_push[i]) r_seen[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_iter_start = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_end_all) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!(|w_nonempty) && !(|w_push)) w_state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        if ((|r_seen) && (r_iteration_id < MAX_ITERATION)) begin
          w_iter_start = 1'b1;
          w_state_nxt  = S_RUN;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_RUN;
      r_iteration_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_iter_start) r_iteration_id <= r_iteration_id + ITERATION_WIDTH'(1);
    end
  end

  always_comb begin
    next_v_id = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (w_nonempty[i]) next_v_id[i*V_ID_WIDTH +: V_ID_WIDTH] = r_mem[i][r_rd_ptr[i]];
    end
  end

  logic w_unused_iter_id;
  assign w_unused_iter_id = ^front_iteration_id;

`ifdef APPLY_ITER_ID_CHECK_EN
  logic r_iter_mismatch;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iter_mismatch <= 1'b0;
    end else if ((r_state == S_RUN) && front_iteration_end_valid[0] &&
                 (front_iteration_id[ITERATION_WIDTH-1:0] != r_iteration_id)) begin
      r_iter_mismatch <= 1'b1;
    end
  end
  assign iter_mismatch = r_iter_mismatch;
`else
  assign iter_mismatch = 1'b0;
`endif

  assign next_v_valid    = w_nonempty;
  assign stall_front     = r_stall;
  assign overflow_err    = r_overflow;
  assign iteration_start = w_iter_start;
  assign iteration_id    = r_iteration_id;
  assign algorithm_done  = w_done;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_apply_next_frontier_ctrl.sv
// Directed bench for apply_next_frontier_ctrl: 4 lanes, 8-bit IDs, 2-bit iteration counter.
`timescale 1ns/1ps
module tb_apply_next_frontier_ctrl;

  localparam int LN = 4;
  localparam int VW = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [LN*VW-1:0]  f_id;
  logic [LN-1:0]     f_upd, f_val, f_end, f_endv, ready;
  logic [LN*IW-1:0]  f_iter_id;
  logic [LN*VW-1:0]  next_v_id;
  logic [LN-1:0]     next_v_valid, stall_front, overflow_err;
  logic              iteration_start, algorithm_done, iter_mismatch;
  logic [IW-1:0]     iteration_id;
  logic [1:0]        dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [VW-1:0] exp_q[$];

  apply_next_frontier_ctrl #(
    .V_ID_WIDTH(VW), .CORE_NUM(LN), .ITERATION_WIDTH(IW), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .front_active_v_id(f_id), .front_active_v_updated(f_upd),
    .front_active_v_valid(f_val), .front_iteration_end(f_end),
    .front_iteration_end_valid(f_endv), .front_iteration_id(f_iter_id),
    .next_v_ready(ready), .next_v_id(next_v_id), .next_v_valid(next_v_valid),
    .stall_front(stall_front), .iteration_start(iteration_start),
    .iteration_id(iteration_id), .algorithm_done(algorithm_done),
    .overflow_err(overflow_err), .iter_mismatch(iter_mismatch),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    f_id = '0; f_upd = '0; f_val = '0; f_end = '0; f_endv = '0; f_iter_id = '0; ready = '0;
  endtask

  task automatic set_lane(input int lane, input logic v, input logic u, input logic [VW-1:0] id);
    f_val[lane] = v;
    f_upd[lane] = u;
    f_id[lane*VW +: VW] = id;
  endtask

  task automatic set_end(input logic e, input logic [IW-1:0] it);
    f_end = {LN{e}};
    f_endv = {LN{e}};
    f_iter_id = {LN{it}};
  endtask

  function automatic logic [VW-1:0] lane_id(input int lane);
    return next_v_id[lane*VW +: VW];
  endfunction

  typedef struct {
    int            lane;
    logic          v;
    logic          u;
    logic [VW-1:0] id;
    logic [LN-1:0] rdy;
    logic [LN-1:0] exp_valid;
    logic [VW-1:0] exp_id;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int guard;
    int popped;
    logic exp_mm;

    tbl[0] = '{3, 1'b1, 1'b1, 8'd5, 4'hF, 4'b1000, 8'd5};
    tbl[1] = '{3, 1'b1, 1'b1, 8'd6, 4'hF, 4'b1000, 8'd6};
    tbl[2] = '{3, 1'b1, 1'b1, 8'd7, 4'hF, 4'b1000, 8'd7};
    tbl[3] = '{3, 1'b0, 1'b0, 8'd0, 4'hF, 4'b0000, 8'd0};
    tbl[4] = '{0, 1'b1, 1'b0, 8'd9, 4'hF, 4'b0000, 8'd0};
    tbl[5] = '{0, 1'b1, 1'b1, 8'd9, 4'h0, 4'b0001, 8'd9};
    tbl[6] = '{0, 1'b0, 1'b0, 8'd0, 4'h0, 4'b0001, 8'd9};
    tbl[7] = '{0, 1'b0, 1'b0, 8'd0, 4'b0001, 4'b0000, 8'd0};

`ifdef APPLY_ITER_ID_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif

    // reset values
    rst = 1'b0;
    clear_inputs();
    repeat (2) tick();
    chk("rst_valid", next_v_valid, 0);
    chk("rst_id", next_v_id, 0);
    chk("rst_stall", stall_front, 0);
    chk("rst_start", iteration_start, 0);
    chk("rst_iter", iteration_id, 0);
    chk("rst_done", algorithm_done, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_mm", iter_mismatch, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b1;

    // table vectors: lane 3 stream, lane 0 dropped/held/popped
    for (int r = 0; r < 8; r++) begin
      f_val = '0; f_upd = '0;
      set_lane(tbl[r].lane, tbl[r].v, tbl[r].u, tbl[r].id);
      ready = tbl[r].rdy;
      tick();
      chk($sformatf("vec%0d_valid", r), next_v_valid, tbl[r].exp_valid);
      chk($sformatf("vec%0d_id", r), lane_id(tbl[r].lane), tbl[r].exp_id);
    end

    // fill lane 1, stall, overflow, full push+pop, drain
    clear_inputs();
    for (int k = 0; k < 16; k++) begin
      set_lane(1, 1'b1, 1'b1, VW'(100 + k));
      exp_q.push_back(VW'(100 + k));
      tick();
      if (k == 12) chk("stall_pre", stall_front[1], 0);
    end
    chk("stall_full", stall_front[1], 1);
    chk("ovf_none", overflow_err, 0);
    set_lane(1, 1'b1, 1'b1, 8'd99);
    tick();
    chk("ovf_set", overflow_err, 4'b0010);
    chk("ovf_head", lane_id(1), 100);
    ready[1] = 1'b1;
    set_lane(1, 1'b1, 1'b1, 8'd200);
    chk("fullpp_head", lane_id(1), exp_q.pop_front());
    exp_q.push_back(8'd200);
    popped = 1;
    tick();
    f_val = '0; f_upd = '0;
    guard = 0;
    while (next_v_valid[1] && guard < 40) begin
      chk("drain_id", lane_id(1), exp_q.pop_front());
      popped++;
      guard++;
      tick();
    end
    chk("drain_count", popped, 17);
    chk("drain_q_left", exp_q.size(), 0);
    chk("stall_clear", stall_front, 0);
    chk("ovf_sticky", overflow_err, 4'b0010);

    // DRAIN holds while ready is low, then ADVANCE pulses iteration_start
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      set_lane(2, 1'b1, 1'b1, VW'(20 + k));
      exp_q.push_back(VW'(20 + k));
      tick();
    end
    f_val = '0; f_upd = '0;
    set_end(1'b1, 2'd0);
    tick();
    chk("drain_enter", dbg_state, 1);
    set_end(1'b0, 2'd0);
    repeat (3) tick();
    chk("drain_hold", dbg_state, 1);
    chk("drain_hold_valid", next_v_valid, 4'b0100);
    ready[2] = 1'b1;
    guard = 0;
    while (next_v_valid[2] && guard < 20) begin
      chk("drain2_id", lane_id(2), exp_q.pop_front());
      guard++;
      tick();
    end
    chk("drain2_count", guard, 4);
    chk("drain2_start_lo", iteration_start, 0);
    tick();
    chk("adv_state", dbg_state, 2);
    chk("adv_start", iteration_start, 1);
    chk("adv_iter_old", iteration_id, 0);
    tick();
    chk("run1_start_lo", iteration_start, 0);
    chk("run1_iter", iteration_id, 1);
    chk("run1_state", dbg_state, 0);

    // iteration with no updates converges
    clear_inputs();
    set_end(1'b1, 2'd1);
    tick();
    set_end(1'b0, 2'd0);
    tick();
    chk("conv_adv_done", algorithm_done, 1);
    chk("conv_adv_start", iteration_start, 0);
    tick();
    chk("conv_state", dbg_state, 3);
    chk("conv_done", algorithm_done, 1);
    set_lane(0, 1'b1, 1'b1, 8'd55);
    set_end(1'b1, 2'd1);
    repeat (2) tick();
    chk("done_no_push", next_v_valid, 0);
    chk("done_iter", iteration_id, 1);
    chk("done_sticky", algorithm_done, 1);
    chk("done_state", dbg_state, 3);
    chk("done_mm", iter_mismatch, 0);

    // iteration limit: 0..3 then done; mismatch probe in iteration 1
    rst = 1'b0;
    clear_inputs();
    tick();
    chk("rst2_done", algorithm_done, 0);
    chk("rst2_iter", iteration_id, 0);
    chk("rst2_valid", next_v_valid, 0);
    chk("rst2_ovf", overflow_err, 0);
    rst = 1'b1;
    for (int it = 0; it < 4; it++) begin
      clear_inputs();
      ready = 4'hF;
      set_lane(0, 1'b1, 1'b1, VW'(it + 1));
      tick();
      chk($sformatf("lim%0d_push", it), lane_id(0), it + 1);
      f_val = '0; f_upd = '0;
      if (it == 1) begin
        chk("mm_before", iter_mismatch, 0);
        f_endv = 4'b0001;
        f_iter_id = {LN{2'd2}};
        tick();
        chk("mm_probe", iter_mismatch, exp_mm);
        f_endv = '0;
      end
      set_end(1'b1, IW'(it));
      tick();
      set_end(1'b0, 2'd0);
      tick();
      chk($sformatf("lim%0d_start", it), iteration_start, (it < 3) ? 1 : 0);
      chk($sformatf("lim%0d_done", it), algorithm_done, (it == 3) ? 1 : 0);
      tick();
      chk($sformatf("lim%0d_iter", it), iteration_id, (it < 3) ? it + 1 : 3);
    end
    chk("lim_state", dbg_state, 3);
    chk("lim_done", algorithm_done, 1);
    chk("lim_mm_sticky", iter_mismatch, exp_mm);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apply_next_frontier_ctrl.md
Name: apply_next_frontier_ctrl

Overview:
Sits directly downstream of the apply-stage iteration-end combiner. It consumes the per-core registered active-vertex stream and the combined iteration-end flags. Per core, it buffers updated vertex IDs into a FIFO that forms the next frontier. A global FSM drains the FIFOs at iteration end, then either starts the next iteration or declares the algorithm converged.

Parameters:
V_ID_WIDTH, `V_ID_WIDTH, vertex ID width per core lane
CORE_NUM, `CORE_NUM, number of core lanes (32 in current build)
ITERATION_WIDTH, `ITERATION_WIDTH, iteration counter width
FIFO_DEPTH, 16, per-lane frontier FIFO depth; power of two, >= 4
MAX_ITERATION, 2**ITERATION_WIDTH-1, last iteration allowed to run

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
front_active_v_id  in  CORE_NUM*V_ID_WIDTH  per-lane vertex ID
front_active_v_updated  in  CORE_NUM  vertex value changed this iteration
front_active_v_valid  in  CORE_NUM  lane vertex valid
front_iteration_end  in  CORE_NUM  iteration end flag, replicated per lane
front_iteration_end_valid  in  CORE_NUM  iteration end flag valid
front_iteration_id  in  CORE_NUM*ITERATION_WIDTH  upstream iteration ID; only lane 0 is used
next_v_ready  in  CORE_NUM  downstream accepts next_v_id
next_v_id  out  CORE_NUM*V_ID_WIDTH  FIFO head vertex ID
next_v_valid  out  CORE_NUM  FIFO non-empty
stall_front  out  CORE_NUM  registered almost-full backpressure
iteration_start  out  1  one-cycle pulse when a new iteration begins
iteration_id  out  ITERATION_WIDTH  current iteration number
algorithm_done  out  1  sticky convergence / limit flag
overflow_err  out  CORE_NUM  sticky per-lane push-when-full flag
iter_mismatch  out  1  sticky iteration ID mismatch flag (optional feature only)

Behaviour:
- Reset (rst low, async): all FIFOs empty; FSM = RUN; iteration_id = 0; lane counters = 0. All outputs are 0: next_v_valid, next_v_id, stall_front, iteration_start, algorithm_done, overflow_err, iter_mismatch. Reset mid-operation discards all buffered vertices.
- Push: lane i pushes front_active_v_id[i] when front_active_v_valid[i] && front_active_v_updated[i] and FSM is RUN or DRAIN.
  - Valid vertices with updated=0 are dropped.
  - Nothing is pushed in ADVANCE or DONE.
- Push latency: a vertex sampled at edge k is visible as next_v_valid/next_v_id in the cycle after edge k. The FIFO head is read combinationally from storage.
- Pop: occurs on next_v_valid[i] && next_v_ready[i]. The next entry appears the following cycle.
- Full + push + pop in the same cycle: push is accepted and the count is unchanged.
- Full + push, no pop: the vertex is dropped and overflow_err[i] is set. overflow_err is sticky until reset.
- Empty: next_v_valid = 0 and next_v_id = 0.
- stall_front[i]: registered; high in the cycle after the lane count reaches >= FIFO_DEPTH-2. This covers the 2-cycle upstream register latency.
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- Lane updated counter: 1 bit of "seen" per lane. Set on any accepted push during the current iteration; cleared on iteration_start.
- end_all = AND of all (front_iteration_end & front_iteration_end_valid) lanes.
- FSM:
  - RUN: end_all -> DRAIN.
  - DRAIN: wait until all FIFOs are empty and no push occurs this cycle -> ADVANCE.
  - ADVANCE (exactly 1 cycle):
    - If any seen bit is set and iteration_id < MAX_ITERATION: iteration_start = 1 for one cycle, iteration_id += 1, seen bits cleared, -> RUN.
    - Otherwise: algorithm_done = 1, -> DONE.
  - DONE: absorbing until reset. algorithm_done stays 1; inputs are ignored; FIFOs are already empty.
- end_all asserted while in DRAIN, ADVANCE or DONE is ignored.
- iteration_id never wraps; MAX_ITERATION terminates the algorithm.

Optional Feature:
Macro: APPLY_ITER_ID_CHECK_EN.
- Defined: in RUN, any cycle where front_iteration_end_valid[0]=1 and front_iteration_id[ITERATION_WIDTH-1:0] != iteration_id sets iter_mismatch. iter_mismatch is sticky until reset.
- Undefined: front_iteration_id is unused, iter_mismatch is tied to 0, and no comparator is built.

Test Plan:
- Reset, then lane 3 pushes IDs 5,6,7 with updated=1 and next_v_ready=1 -> next_v_id[3] shows 5,6,7 on consecutive cycles, each one cycle after input; all other lanes have next_v_valid=0.
- Lane 0 gets valid=1, updated=0, ID 9 -> no push; next_v_valid[0] stays 0.
- next_v_ready[1]=0 and 16 pushes to lane 1 -> stall_front[1] rises after the 14th push. A 17th push sets overflow_err[1] and is dropped; draining then yields exactly 16 entries.
- 4 vertices pushed, then end_all=1 with ready=0 -> FSM holds in DRAIN. Releasing ready drains 4 entries; the cycle after empty, iteration_start pulses and iteration_id goes 0 -> 1.
- Iteration with no updated vertices followed by end_all -> after DRAIN and ADVANCE, algorithm_done=1 with no iteration_start pulse. Further input is ignored.
- ITERATION_WIDTH=2 and MAX_ITERATION=3, every iteration updates -> iteration_id runs 0 to 3, then algorithm_done=1. With APPLY_ITER_ID_CHECK_EN, front_iteration_id[0]=2 while iteration_id=1 -> iter_mismatch=1.
